// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_valid,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_flush,
    output logic            o_stall,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*XLEN-1:0]  r_acc;
    logic [XLEN-1:0]    r_b;
    logic [1:0]         r_op;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_valid;
    logic [XLEN-1:0]    r_result;

    logic              w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
    logic [XLEN-1:0]   w_abs_a, w_abs_b;
    logic              w_is_div, w_div0, w_ovf, w_special, w_accept;
    logic [XLEN-1:0]   w_special_res;
    logic [XLEN:0]     w_mul_sum, w_shift, w_diff;
    logic [2*XLEN-1:0] w_mul_next, w_div_next, w_prod_fix;
    logic [XLEN-1:0]   w_mul_res, w_div_res, w_q, w_r;

    // Signedness of A: MUL, MULH, MULHSU, DIV, REM; of B: MUL, MULH, DIV, REM
    assign w_a_sgn = !i_op[0] || (i_op == 3'd1);
    assign w_b_sgn = (!i_op[2] && !i_op[1]) || (i_op[2] && !i_op[0]);
    assign w_a_neg = w_a_sgn && i_rs1[XLEN-1];
    assign w_b_neg = w_b_sgn && i_rs2[XLEN-1];
    assign w_abs_a = w_a_neg ? -i_rs1 : i_rs1;
    assign w_abs_b = w_b_neg ? -i_rs2 : i_rs2;

    assign w_is_div  = i_op[2];
    assign w_div0    = (i_rs2 == '0);
    assign w_ovf     = !i_op[0] && (i_rs1 == MIN_NEG) && (i_rs2 == '1);
    assign w_special = w_is_div && (w_div0 || w_ovf);
    assign w_accept  = (r_state == S_IDLE) && i_valid && !i_flush;

    always_comb begin
        w_special_res = '0;
        if (w_div0)
            w_special_res = i_op[1] ? i_rs1 : '1;
        else
            w_special_res = i_op[1] ? '0 : i_rs1;
    end

    // Multiply: high half accumulates |A| while the low half shifts out |B|
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]}
                      + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
    assign w_prod_fix = r_neg_q ? -w_mul_next : w_mul_next;
    assign w_mul_res  = (r_op == 2'd0) ? w_prod_fix[XLEN-1:0]
                                       : w_prod_fix[2*XLEN-1:XLEN];

    // Divide: remainder in the high half, quotient shifts in at the bottom
    assign w_shift    = r_acc[2*XLEN-1:XLEN-1];
    assign w_diff     = w_shift - {1'b0, r_b};
    assign w_div_next = w_diff[XLEN]
                      ? {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                      : {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    assign w_q        = w_div_next[XLEN-1:0];
    assign w_r        = w_div_next[2*XLEN-1:XLEN];
    assign w_div_res  = r_op[1] ? (r_neg_r ? -w_r : w_r)
                                : (r_neg_q ? -w_q : w_q);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fast, w_fast_fix;
    logic [XLEN-1:0]   w_fast_res;
    assign w_fast     = (2*XLEN)'(w_abs_a) * (2*XLEN)'(w_abs_b);
    assign w_fast_fix = (w_a_neg ^ w_b_neg) ? -w_fast : w_fast;
    assign w_fast_res = (i_op[1:0] == 2'd0) ? w_fast_fix[XLEN-1:0]
                                            : w_fast_fix[2*XLEN-1:XLEN];
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_valid  <= 1'b0;
            r_result <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= i_op[1:0];
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_cnt   <= '0;
                        if (w_special) begin
                            r_result <= w_special_res;
                            r_valid  <= 1'b1;
                            r_state  <= S_DONE;
                        end else if (w_is_div) begin
                            r_acc   <= {{XLEN{1'b0}}, w_abs_a};
                            r_b     <= w_abs_b;
                            r_state <= S_DIV;
                        end else begin
`ifdef MULDIV_FAST_MUL_EN
                            r_result <= w_fast_res;
                            r_valid  <= 1'b1;
                            r_state  <= S_DONE;
`else
                            r_acc   <= {{XLEN{1'b0}}, w_abs_b};
                            r_b     <= w_abs_a;
                            r_state <= S_MUL;
`endif
                        end
                    end
                end
                S_MUL: begin
                    if (i_flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_mul_next;
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == LAST) begin
                            r_result <= w_mul_res;
                            r_valid  <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_DIV: begin
                    if (i_flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_div_next;
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == LAST) begin
                            r_result <= w_div_res;
                            r_valid  <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_stall  = !i_reset && (w_accept || (r_state == S_MUL)
                                            || (r_state == S_DIV));
    assign o_valid  = r_valid;
    assign o_result = r_result;

endmodule
